fre_gen: RTL and testbench

// - Programmable square-wave source: the transmit end of the fre_count measurement path.
// - Takes a 4-digit BCD frequency setpoint in Hz, in the same format fre_count reports on QO.
// - Converts the setpoint to a half-period divisor and drives signal at that frequency.
// - Used as the stimulus source for fre_count in loop-back and on-board self-test.

---
 rtl/fre_pkg.sv | 39 +++
 rtl/fre_div.sv | 67 ++++++
 rtl/fre_gen.sv | 186 ++++++++++++++++++
 tb/tb_fre_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fre_pkg.sv
// fre_pkg: definitions shared by the fre_gen / fre_count measurement path.
//   - FSM state encoding used by fre_gen (exported on its debug port)
//   - BCD setpoint geometry and the default system clock frequency
//   - small BCD helpers used by the accumulator and the range check
package fre_pkg;

  localparam int BCD_DIGITS   = 4;
  localparam int BCD_W        = 16;
  localparam int ACC_W        = 14;        // holds 9999 (and any 4-nibble overflow stays harmless)
  localparam int DEF_CLK_FREQ = 5_000_000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BCD  = 3'd1,
    ST_CHK  = 3'd2,
    ST_DIV  = 3'd3,
    ST_RUN  = 3'd4
  } fre_state_t;

  // Digit selector, most significant digit first: idx 0 = thousands.
  function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] v,
                                           input logic [1:0]       idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = v[15:12];
      2'd1:    d = v[11:8];
      2'd2:    d = v[7:4];
      default: d = v[3:0];
    endcase
    return d;
  endfunction

  // True when any nibble is outside 0..9.
  function automatic logic bcd_any_bad(input logic [BCD_W-1:0] v);
    return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
           (v[7:4]   > 4'd9) || (v[3:0]  > 4'd9);
  endfunction

endpackage

// File: rtl/fre_div.sv
// fre_div: sequential restoring divider, one quotient bit per clock.
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   start     in   1-cycle pulse: capture dividend/divisor, begin dividing
//   dividend  in   DIV_W bits
//   divisor   in   DIV_W bits, must be non-zero when start is pulsed
//   done      out  1-cycle pulse, DIV_W cycles after start; quotient valid
//   quotient  out  DIV_W bits, holds its value until the next start
// The first quotient bit is produced on the start edge itself, so done is
// seen exactly DIV_W cycles after the start cycle.
module fre_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int LW = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] dvs;
  logic [LW-1:0]    left;

  // One restoring step on {remainder, quotient-shift-register}.
  // The subtraction is done modulo 2^DIV_W: when it is taken the true
  // result is below the divisor, so the dropped top bit is always zero.
  function automatic logic [2*DIV_W-1:0] div_step(input logic [DIV_W-1:0] r,
                                                  input logic [DIV_W-1:0] q,
                                                  input logic [DIV_W-1:0] d);
    logic [DIV_W:0] sh;
    sh = {r, q[DIV_W-1]};
    if (sh >= {1'b0, d})
      return {sh[DIV_W-1:0] - d, q[DIV_W-2:0], 1'b1};
    else
      return {sh[DIV_W-1:0], q[DIV_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      left <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem, quo} <= div_step('0, dividend, divisor);
        dvs        <= divisor;
        left       <= LW'(DIV_W - 1);
      end else if (left != '0) begin
        {rem, quo} <= div_step(rem, quo, dvs);
        left       <= left - LW'(1);
        if (left == LW'(1)) done <= 1'b1;
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/fre_gen.sv
// fre_gen: programmable square-wave source driven by a 4-digit BCD setpoint (Hz).
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   load       in   1-cycle request: sample fset and retune
//   fset       in   BCD setpoint, [15:12] thousands .. [3:0] units
//   en         in   output enable (0 forces signal low, phase counter held at 0)
//   signal     out  generated square wave, period 2*half clk cycles
//   busy       out  setpoint conversion / division in progress
//   valid      out  a legal divisor is installed and the generator runs
//   err        out  last accepted setpoint was illegal
//   dbg_state  out  current FSM state
//
// Handshake: load is a single-cycle request with no acknowledge. It is taken
// on a rising edge only while busy=0 (FSM in IDLE or RUN); a load seen while
// busy=1 is dropped. busy rises the cycle after acceptance and stays high for
// DIV_W+5 cycles (legal setpoint) or 5 cycles (illegal). valid/err are
// updated on the edge on which busy falls.
module fre_gen
  import fre_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int DIV_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] fset,
  input  logic             en,
  output logic             signal,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output fre_state_t       dbg_state
);

  fre_state_t state, state_nx;

  logic [BCD_W-1:0] fset_q;
  logic [1:0]       dig_idx;
  logic [ACC_W-1:0] acc;

  logic [DIV_W-1:0] half;     // active half period
  logic [DIV_W-1:0] hnew;     // pending half period, adopted at the next toggle
  logic [DIV_W-1:0] cnt;

  logic             accept;
  logic             chk_bad;
  logic             div_start;
  logic             div_done;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_q_fix;
  logic [DIV_W-1:0] two_acc;

  logic [DIV_W-1:0] cnt_nx;
  logic [DIV_W-1:0] half_nx;
  logic             sig_nx;

  assign accept  = load && ((state == ST_IDLE) || (state == ST_RUN));
  assign two_acc = DIV_W'({acc, 1'b0});

  // Range check on the fully accumulated setpoint.
  assign chk_bad = bcd_any_bad(fset_q) || (acc == '0) ||
                   (two_acc > DIV_W'(CLK_FREQ));

  // A quotient of zero cannot occur for a legal setpoint; clamp anyway so a
  // running generator never sees half=0.
  assign div_q_fix = (div_q == '0) ? DIV_W'(1) : div_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_BCD;
      ST_BCD:  if (dig_idx == 2'(BCD_DIGITS - 1)) state_nx = ST_CHK;
      ST_CHK: begin
        if (chk_bad) begin
          state_nx = ST_IDLE;
        end else begin
          div_start = 1'b1;
          state_nx  = ST_DIV;
        end
      end
      ST_DIV:  if (div_done) state_nx = ST_RUN;
      ST_RUN:  if (accept) state_nx = ST_BCD;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_BCD) || (state == ST_CHK) || (state == ST_DIV);
  assign dbg_state = state;

  // ------------------------------------------------- BCD accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fset_q  <= '0;
      acc     <= '0;
      dig_idx <= '0;
    end else if (accept) begin
      fset_q  <= fset;
      acc     <= '0;
      dig_idx <= '0;
    end else if (state == ST_BCD) begin
      acc     <= acc * ACC_W'(10) + ACC_W'(bcd_digit(fset_q, dig_idx));
      dig_idx <= dig_idx + 2'd1;
    end
  end

  // ------------------------------------------------------- divider
  fre_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (DIV_W'(CLK_FREQ)),
    .divisor  (two_acc),
    .done     (div_done),
    .quotient (div_q)
  );

  // --------------------------------------------- phase counter step
  // Next phase-counter values for one running cycle. half only changes on
  // a toggle, which keeps every emitted phase a whole old or new half.
  always_comb begin
    cnt_nx  = cnt;
    sig_nx  = signal;
    half_nx = half;
    if (!en) begin
      cnt_nx = '0;
      sig_nx = 1'b0;
    end else if (cnt == half - DIV_W'(1)) begin
      cnt_nx  = '0;
      sig_nx  = ~signal;
      half_nx = hnew;
    end else begin
      cnt_nx = cnt + DIV_W'(1);
    end
  end

  // ----------------------------------- status and waveform registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signal <= 1'b0;
      valid  <= 1'b0;
      err    <= 1'b0;
      half   <= '0;
      hnew   <= '0;
      cnt    <= '0;
    end else begin
      if (accept) err <= 1'b0;

      if ((state == ST_CHK) && chk_bad) begin
        // Illegal setpoint stops the generator at once, even mid-retune.
        err    <= 1'b1;
        valid  <= 1'b0;
        signal <= 1'b0;
        half   <= '0;
        hnew   <= '0;
        cnt    <= '0;
      end else if ((state == ST_DIV) && div_done) begin
        valid <= 1'b1;
        hnew  <= div_q_fix;
        if (!valid) begin
          // Starting from IDLE: install directly, waveform starts low.
          half   <= div_q_fix;
          cnt    <= '0;
          signal <= 1'b0;
        end else begin
          // Retune: keep the running phase; hnew is picked up at a toggle.
          cnt    <= cnt_nx;
          signal <= sig_nx;
          half   <= half_nx;
        end
      end else if (valid) begin
        cnt    <= cnt_nx;
        signal <= sig_nx;
        half   <= half_nx;
      end
    end
  end

endmodule

// File: tb/tb_fre_gen.sv
// tb_fre_gen: self-checking bench for fre_gen (CLK_FREQ=5_000_000, DIV_W=24).
// Expected values come from a setpoint model: decimal value of the BCD word,
// legality from the digit/zero/range rules, half = max(1, CLK_FREQ/(2*value)),
// busy length DIV_W+5 or 5, and waveform phases of exactly half cycles.
module tb_fre_gen;
  import fre_pkg::*;

  localparam int CLK_FREQ = 5_000_000;
  localparam int DIV_W    = 24;
  localparam int BOUND    = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] fset;
  logic        en;
  logic        signal;
  logic        busy;
  logic        valid;
  logic        err;
  fre_state_t  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] fset;
    bit          legal;
    int          busy_cyc;
    int          half;
    bit          measure;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  fre_gen #(.CLK_FREQ(CLK_FREQ), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .fset      (fset),
    .en        (en),
    .signal    (signal),
    .busy      (busy),
    .valid     (valid),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ------------------------------------------------ reference model
  function automatic int bcd_value(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit model_legal(input logic [15:0] v);
    int val;
    for (int i = 0; i < 4; i++)
      if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
    val = bcd_value(v);
    return (val != 0) && (2 * val <= CLK_FREQ);
  endfunction

  function automatic int model_half(input logic [15:0] v);
    int h;
    h = CLK_FREQ / (2 * bcd_value(v));
    return (h < 1) ? 1 : h;
  endfunction

  // ---------------------------------------------------- utilities
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Pulse load for one cycle, then count the cycles busy stays high.
  task automatic do_load(input logic [15:0] v, output int nbusy);
    fset  = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 200) begin
      nbusy++;
      tick();
    end
  endtask

  // Cycles until signal changes level (bounded).
  task automatic measure_phase(output int n);
    logic s0;
    s0 = signal;
    n  = 0;
    while (signal === s0 && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int highs;
    highs = 0;
    repeat (cycles) begin
      tick();
      if (signal !== 1'b0) highs++;
    end
    check(name, highs, 0);
  endtask

  // Pop an expected phase length and compare with a measured one.
  task automatic check_phase(input string name);
    int n;
    logic [31:0] e;
    measure_phase(n);
    e = exp_q.pop_front();
    check(name, n, e);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: time budget exceeded (tests=%0d failed=%0d)", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int n;
    logic [15:0] v;
    logic [3:0]  d[4];

    vecs[0] = '{16'h1000, 1'b1, 29, 2500,    1'b1};
    vecs[1] = '{16'h9999, 1'b1, 29, 250,     1'b1};
    vecs[2] = '{16'h00A5, 1'b0, 5,  0,       1'b0};
    vecs[3] = '{16'h0000, 1'b0, 5,  0,       1'b0};
    vecs[4] = '{16'h0500, 1'b1, 29, 5000,    1'b1};
    vecs[5] = '{16'h2000, 1'b1, 29, 1250,    1'b1};
    vecs[6] = '{16'h0999, 1'b1, 29, 2502,    1'b1};
    vecs[7] = '{16'h0001, 1'b1, 29, 2500000, 1'b0};
    vecs[8] = '{16'hF000, 1'b0, 5,  0,       1'b0};
    vecs[9] = '{16'h0007, 1'b1, 29, 357142,  1'b0};

    // ------------------------------------------------ reset state
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b1;
    fset = '0;
    tick();
    check("rst_signal", 32'(signal), 0);
    check("rst_busy",   32'(busy),   0);
    check("rst_valid",  32'(valid),  0);
    check("rst_err",    32'(err),    0);
    check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    tick();

    // --------------------------------------------- vector table
    foreach (vecs[i]) begin
      do_reset();
      do_load(vecs[i].fset, nb);
      check($sformatf("vec%0d_busy", i), nb, vecs[i].busy_cyc);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].legal));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(!vecs[i].legal));
      check($sformatf("vec%0d_sig0", i), 32'(signal), 0);
      if (vecs[i].measure) begin
        measure_phase(n);
        check($sformatf("vec%0d_low", i), n, vecs[i].half);
        measure_phase(n);
        check($sformatf("vec%0d_high", i), n, vecs[i].half);
      end else if (!vecs[i].legal) begin
        check_quiet($sformatf("vec%0d_quiet", i), 50);
      end
    end

    // --------------------------------- randomized vs. model
    repeat (6) begin
      d[3] = 4'($urandom_range(2, 9));
      d[2] = 4'($urandom_range(0, 9));
      d[1] = 4'($urandom_range(0, 9));
      d[0] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
      v = {d[3], d[2], d[1], d[0]};
      do_reset();
      do_load(v, nb);
      check($sformatf("rnd_%h_busy", v), nb, model_legal(v) ? DIV_W + 5 : 5);
      check($sformatf("rnd_%h_valid", v), 32'(valid), 32'(model_legal(v)));
      check($sformatf("rnd_%h_err", v), 32'(err), 32'(!model_legal(v)));
      if (model_legal(v)) begin
        exp_q.push_back(32'(model_half(v)));
        exp_q.push_back(32'(model_half(v)));
        check_phase($sformatf("rnd_%h_low", v));
        check_phase($sformatf("rnd_%h_high", v));
      end else begin
        check_quiet($sformatf("rnd_%h_quiet", v), 30);
      end
    end

    // ------------------------- retune 1000 -> 2000 while running
    do_reset();
    do_load(16'h1000, nb);
    measure_phase(n);                 // first low phase; now at a rising toggle
    check("retune_first_low", n, 2500);
    fset = 16'h2000;
    load = 1'b1;
    tick();
    load = 1'b0;
    n = 1;
    while (signal === 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    check("retune_old_phase", n, 2500);
    exp_q.push_back(32'd1250);
    exp_q.push_back(32'd1250);
    check_phase("retune_new_phase0");
    check_phase("retune_new_phase1");
    check("retune_valid", 32'(valid), 1);
    check("retune_err",   32'(err),   0);

    // ------------------------------- illegal retune stops at once
    do_load(16'h00A5, nb);
    check("bad_retune_busy",  nb, 5);
    check("bad_retune_err",   32'(err),    1);
    check("bad_retune_valid", 32'(valid),  0);
    check("bad_retune_sig",   32'(signal), 0);
    check_quiet("bad_retune_quiet", 100);

    // ------------------------------------ load while busy ignored
    do_reset();
    fset = 16'h1000;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    fset = 16'h9999;
    load = 1'b1;
    tick();
    load = 1'b0;
    nb = 3;
    while (busy === 1'b1 && nb < 200) begin
      nb++;
      tick();
    end
    check("busyload_busy", nb, 29);
    measure_phase(n);
    check("busyload_half", n, 2500);

    // ------------------------------------------ en low then high
    en = 1'b0;
    tick();
    check("en_low_sig", 32'(signal), 0);
    check_quiet("en_low_quiet", 3000);
    en = 1'b1;
    measure_phase(n);
    check("en_rise_first_high", n, 2500);

    // ------------------------------- reset mid-DIV during retune
    fset = 16'h2000;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (10) tick();
    check("middiv_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("middiv_rst_sig",   32'(signal), 0);
    check("middiv_rst_busy",  32'(busy),   0);
    check("middiv_rst_valid", 32'(valid),  0);
    check("middiv_rst_err",   32'(err),    0);
    tick();
    rst = 1'b1;
    tick();
    do_load(16'h0500, nb);
    check("after_rst_busy",  nb, 29);
    check("after_rst_valid", 32'(valid), 1);
    measure_phase(n);
    check("after_rst_half", n, 5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
